d_stage_reg: RTL and testbench

//  IF/ID pipeline register for the P7 five-stage MIPS core. Captures the fetched

---
 rtl/d_stage_reg_if.sv | 28 ++
 rtl/d_stage_reg.sv | 123 ++++++++++++
 tb/tb_d_stage_reg.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/d_stage_reg_if.sv
// IF/ID stage-register bus: fetch-side inputs, pipeline control and D-stage outputs.
// The master drives fetch/control signals; the slave is the stage register itself.
interface d_stage_reg_if;
    logic        stall;
    logic        flush;
    logic        req;
    logic [31:0] f_instr;
    logic [31:0] f_pc;
    logic [4:0]  f_exc_code;
    logic        f_bd;
    logic [31:0] d_instr;
    logic [31:0] d_pc;
    logic [4:0]  d_exc_code;
    logic        d_bd;
    logic        d_valid;
    logic [15:0] d_imm16;
    logic [1:0]  d_ext_sel;

    modport master (
        output stall, flush, req, f_instr, f_pc, f_exc_code, f_bd,
        input  d_instr, d_pc, d_exc_code, d_bd, d_valid, d_imm16, d_ext_sel
    );

    modport slave (
        input  stall, flush, req, f_instr, f_pc, f_exc_code, f_bd,
        output d_instr, d_pc, d_exc_code, d_bd, d_valid, d_imm16, d_ext_sel
    );
endinterface

// File: rtl/d_stage_reg.sv
// IF/ID pipeline register for the P7 MIPS core, with a zero-latency extender-select decode.
// Optional macro D_REG_RI_EN adds reserved-instruction (RI, code 10) detection on load.
module d_stage_reg #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
    input  logic          clk,
    input  logic          reset,
    d_stage_reg_if.slave  bus
);

    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
`ifdef D_REG_RI_EN
    localparam logic [4:0] EXC_RI   = 5'd10;
`endif

    logic [31:0] r_instr;
    logic [31:0] r_pc;
    logic [4:0]  r_exc_code;
    logic        r_bd;
    logic        r_valid;

    logic [5:0]  w_op;
    logic [1:0]  w_ext_sel;
    logic [31:0] w_load_instr;
    logic [4:0]  w_load_exc;

`ifdef D_REG_RI_EN
    // True when the instruction belongs to the P7 set (ALU, mul/div, branches, jumps, loads/stores, CP0).
    function automatic logic isP7Instr(input logic [31:0] instr);
        logic [5:0] op;
        logic [5:0] funct;
        logic [4:0] rs;
        logic [4:0] rt;
        op    = instr[31:26];
        funct = instr[5:0];
        rs    = instr[25:21];
        rt    = instr[20:16];
        case (op)
            6'h00: isP7Instr = funct inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
                                             6'h08, 6'h09, 6'h0C, 6'h10, 6'h11, 6'h12,
                                             6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B, 6'h20,
                                             6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
                                             6'h27, 6'h2A, 6'h2B};
            6'h01: isP7Instr = (rt == 5'd0) || (rt == 5'd1);
            6'h10: isP7Instr = (rs == 5'd0) || (rs == 5'd4) ||
                               ((rs == 5'd16) && (funct == 6'h18));
            default: isP7Instr = op inside {6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07,
                                            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D,
                                            6'h0E, 6'h0F, 6'h20, 6'h21, 6'h23, 6'h24,
                                            6'h25, 6'h28, 6'h29, 6'h2B};
        endcase
    endfunction
`endif

    // A fetch address error never delivers a real instruction word; RI only applies to clean fetches.
    always_comb begin
        w_load_exc   = bus.f_exc_code;
        w_load_instr = bus.f_instr;
        if (bus.f_exc_code == EXC_ADEL) begin
            w_load_instr = 32'd0;
        end
`ifdef D_REG_RI_EN
        if ((bus.f_exc_code == EXC_NONE) && !isP7Instr(bus.f_instr)) begin
            w_load_exc = EXC_RI;
        end
`endif
    end

    // Exception entry beats stall, and stall beats flush so a held bubble is never overwritten.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_instr    <= 32'd0;
            r_pc       <= RESET_PC;
            r_exc_code <= EXC_NONE;
            r_bd       <= 1'b0;
            r_valid    <= 1'b0;
        end else if (bus.req) begin
            r_instr    <= 32'd0;
            r_pc       <= HANDLER_PC;
            r_exc_code <= EXC_NONE;
            r_bd       <= 1'b0;
            r_valid    <= 1'b0;
        end else if (!bus.stall) begin
            if (bus.flush) begin
                r_instr    <= 32'd0;
                r_pc       <= bus.f_pc;
                r_exc_code <= EXC_NONE;
                r_bd       <= 1'b0;
                r_valid    <= 1'b0;
            end else begin
                r_instr    <= w_load_instr;
                r_pc       <= bus.f_pc;
                r_exc_code <= w_load_exc;
                r_bd       <= bus.f_bd;
                r_valid    <= 1'b1;
            end
        end
    end

    assign w_op = r_instr[31:26];

    always_comb begin
        w_ext_sel = 2'b00;
        case (w_op)
            6'b001111:                            w_ext_sel = 2'b10;
            6'b001100, 6'b001101, 6'b001110:      w_ext_sel = 2'b01;
            6'b000100, 6'b000101, 6'b000110,
            6'b000111, 6'b000001:                 w_ext_sel = 2'b11;
            default:                              w_ext_sel = 2'b00;
        endcase
    end

    assign bus.d_instr    = r_instr;
    assign bus.d_pc       = r_pc;
    assign bus.d_exc_code = r_exc_code;
    assign bus.d_bd       = r_bd;
    assign bus.d_valid    = r_valid;
    assign bus.d_imm16    = r_instr[15:0];
    assign bus.d_ext_sel  = w_ext_sel;

endmodule

// File: tb/tb_d_stage_reg.sv
// Self-checking bench for d_stage_reg: directed scenarios plus randomized traffic against a reference model.
// Honours D_REG_RI_EN in its expectations when the macro is defined.
module tb_d_stage_reg;

    localparam logic [31:0] RESET_PC   = 32'h0000_3000;
    localparam logic [31:0] HANDLER_PC = 32'h0000_4180;

    logic clk;
    logic reset;
    int   checkCount;
    int   failCount;

    d_stage_reg_if bus ();

    d_stage_reg #(
        .RESET_PC   (RESET_PC),
        .HANDLER_PC (HANDLER_PC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference view of the stage register contents
    logic [31:0] mInstr;
    logic [31:0] mPc;
    logic [4:0]  mExc;
    logic        mBd;
    logic        mValid;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic logic [1:0] expExtSel(input logic [5:0] op);
        if (op == 6'd15)                             return 2'b10;
        if (op >= 6'd12 && op <= 6'd14)              return 2'b01;
        if ((op >= 6'd4 && op <= 6'd7) || op == 6'd1) return 2'b11;
        return 2'b00;
    endfunction

`ifdef D_REG_RI_EN
    function automatic bit p7Supported(input logic [31:0] instr);
        logic [5:0] op;
        op = instr[31:26];
        if (op == 6'h00)
            return instr[5:0] inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h09,
                                      6'h0C, 6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19, 6'h1A,
                                      6'h1B, [6'h20:6'h27], 6'h2A, 6'h2B};
        if (op == 6'h01) return instr[20:16] <= 5'd1;
        if (op == 6'h10)
            return (instr[25:21] == 5'd0) || (instr[25:21] == 5'd4) ||
                   (instr[25:21] == 5'd16 && instr[5:0] == 6'h18);
        return op inside {[6'h02:6'h0F], 6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B};
    endfunction
`endif

    task automatic modelReset();
        mInstr = 32'd0; mPc = RESET_PC; mExc = 5'd0; mBd = 1'b0; mValid = 1'b0;
    endtask

    // Next state from the current fetch inputs, applied at a rising edge
    task automatic modelClock();
        if (bus.req) begin
            mInstr = 32'd0; mPc = HANDLER_PC; mExc = 5'd0; mBd = 1'b0; mValid = 1'b0;
        end else if (bus.stall) begin
            // hold
        end else if (bus.flush) begin
            mInstr = 32'd0; mPc = bus.f_pc; mExc = 5'd0; mBd = 1'b0; mValid = 1'b0;
        end else begin
            mInstr = (bus.f_exc_code == 5'd4) ? 32'd0 : bus.f_instr;
            mPc    = bus.f_pc;
            mExc   = bus.f_exc_code;
            mBd    = bus.f_bd;
            mValid = 1'b1;
`ifdef D_REG_RI_EN
            if (bus.f_exc_code == 5'd0 && !p7Supported(bus.f_instr)) mExc = 5'd10;
`endif
        end
    endtask

    task automatic compareAll(input string tag);
        checkOutput({tag, ".instr"}, bus.d_instr, mInstr);
        checkOutput({tag, ".pc"},    bus.d_pc,    mPc);
        checkOutput({tag, ".exc"},   32'(bus.d_exc_code), 32'(mExc));
        checkOutput({tag, ".bd"},    32'(bus.d_bd),       32'(mBd));
        checkOutput({tag, ".valid"}, 32'(bus.d_valid),    32'(mValid));
        checkOutput({tag, ".imm16"}, 32'(bus.d_imm16),    32'(mInstr[15:0]));
        checkOutput({tag, ".ext"},   32'(bus.d_ext_sel),  32'(expExtSel(mInstr[31:26])));
    endtask

    task automatic applyStimulus(input logic st, input logic fl, input logic rq,
                                 input logic [31:0] instr, input logic [31:0] pc,
                                 input logic [4:0] exc, input logic bd);
        bus.stall = st; bus.flush = fl; bus.req = rq;
        bus.f_instr = instr; bus.f_pc = pc; bus.f_exc_code = exc; bus.f_bd = bd;
    endtask

    task automatic stepCycle(input string tag);
        @(posedge clk);
        modelClock();
        @(negedge clk);
        compareAll(tag);
    endtask

    logic [5:0] opList [13] = '{6'h0f, 6'h0c, 6'h0d, 6'h0e, 6'h04, 6'h05, 6'h06,
                                6'h07, 6'h01, 6'h00, 6'h23, 6'h2b, 6'h3f};

    initial begin
        checkCount = 0;
        failCount  = 0;
        applyStimulus(0, 0, 0, 32'd0, 32'd0, 5'd0, 0);
        reset = 1'b1;
        modelReset();
        repeat (2) @(negedge clk);
        compareAll("reset");
        reset = 1'b0;

        // Lui load: immediate and extender select visible the cycle after capture
        applyStimulus(0, 0, 0, 32'h3C01_1234, 32'h0000_3004, 5'd0, 0);
        stepCycle("lui");
        checkOutput("lui.imm16", 32'(bus.d_imm16), 32'h1234);
        checkOutput("lui.ext", 32'(bus.d_ext_sel), 32'h2);
        checkOutput("lui.valid", 32'(bus.d_valid), 32'h1);

        // Stall plus flush holds everything while the fetch side keeps changing
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 1, 0, 32'h2000_0000 + 32'(i), 32'h0000_5000 + 32'(4 * i), 5'd0, 1);
            stepCycle("stallFlush");
            checkOutput("stallFlush.instr", bus.d_instr, 32'h3C01_1234);
            checkOutput("stallFlush.pc", bus.d_pc, 32'h0000_3004);
        end

        // Exception entry wins over stall
        applyStimulus(1, 0, 1, 32'h3421_FFFF, 32'h0000_3008, 5'd0, 0);
        stepCycle("req");
        checkOutput("req.instr", bus.d_instr, 32'h0);
        checkOutput("req.pc", bus.d_pc, 32'h0000_4180);
        checkOutput("req.valid", 32'(bus.d_valid), 32'h0);
        checkOutput("req.ext", 32'(bus.d_ext_sel), 32'h0);

        // Fetch address error squashes the instruction word
        applyStimulus(0, 0, 0, 32'h1000_FFFF, 32'h0000_3001, 5'd4, 0);
        stepCycle("adel");
        checkOutput("adel.instr", bus.d_instr, 32'h0);
        checkOutput("adel.exc", 32'(bus.d_exc_code), 32'd4);
        checkOutput("adel.pc", bus.d_pc, 32'h0000_3001);

        // Unknown opcode: RI only when the detector is built in
        applyStimulus(0, 0, 0, 32'hFC00_0000, 32'h0000_300C, 5'd0, 0);
        stepCycle("ri");
`ifdef D_REG_RI_EN
        checkOutput("ri.exc", 32'(bus.d_exc_code), 32'd10);
`else
        checkOutput("ri.exc", 32'(bus.d_exc_code), 32'd0);
`endif
        checkOutput("ri.instr", bus.d_instr, 32'hFC00_0000);

        // Flush records the fetch PC in the bubble
        applyStimulus(0, 1, 0, 32'h3421_0001, 32'h0000_3010, 5'd0, 1);
        stepCycle("flush");
        checkOutput("flush.pc", bus.d_pc, 32'h0000_3010);
        checkOutput("flush.valid", 32'(bus.d_valid), 32'h0);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            applyStimulus(($urandom_range(0, 4) == 0), ($urandom_range(0, 5) == 0),
                          ($urandom_range(0, 15) == 0),
                          {opList[$urandom_range(0, 12)], 26'($urandom)},
                          $urandom,
                          ($urandom_range(0, 7) == 0) ? 5'd4 : 5'd0,
                          1'($urandom));
            stepCycle("rand");
        end

        // Asynchronous reset mid-cycle, held across an edge, then released
        applyStimulus(1, 0, 0, 32'h3C01_ABCD, 32'h0000_6000, 5'd0, 1);
        #2 reset = 1'b1;
        #1;
        modelReset();
        compareAll("asyncReset");
        @(negedge clk);
        compareAll("resetHeld");
        reset = 1'b0;
        applyStimulus(0, 0, 0, 32'h3421_8000, 32'h0000_3000, 5'd0, 0);
        stepCycle("afterReset");
        checkOutput("afterReset.ext", 32'(bus.d_ext_sel), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
